// File: rtl/dbg_pkg.sv
// Shared types and constants for the RV32 core debug-port scan controller.
package dbg_pkg;

    localparam int DBG_ADDR_W = 7;
    localparam int DBG_DATA_W = 32;

    // Debug address map: x0-x31 first, then the 32 test signals.
    localparam logic [DBG_ADDR_W-1:0] DBG_REG_BANK  = 7'h00;
    localparam logic [DBG_ADDR_W-1:0] DBG_TEST_BANK = 7'h20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STEP_HI,
        ST_STEP_LO,
        ST_SET_ADDR,
        ST_CAPTURE,
        ST_SEND,
        ST_FINISH
    } scan_state_e;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_HIGH,
        PH_LOW
    } step_phase_e;

    // Sweep address advance that sticks at the last address instead of wrapping.
    function automatic logic [DBG_ADDR_W-1:0] next_addr(input logic [DBG_ADDR_W-1:0] addr,
                                                        input logic [DBG_ADDR_W-1:0] last);
        return (addr == last) ? addr : addr + 1'b1;
    endfunction

endpackage

// File: rtl/dbg_step_pulse.sv
// Generates one debug_step pulse: HIGH_CYC cycles high, then LOW_CYC cycles low.
module dbg_step_pulse
    import dbg_pkg::*;
#(
    parameter int unsigned HIGH_CYC = 4,
    parameter int unsigned LOW_CYC  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic step,
    output logic hi_done,
    output logic done,
    output logic busy
);

    localparam int unsigned MAX_CYC = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] HI_LAST = CNT_W'(HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] LO_LAST = CNT_W'(LOW_CYC - 1);

    step_phase_e      phase;
    logic [CNT_W-1:0] cnt;

    // Phase and cycle counter; reset drops the pulse immediately.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= PH_IDLE;
            cnt   <= '0;
        end else begin
            unique case (phase)
                PH_IDLE: begin
                    if (start) begin
                        phase <= PH_HIGH;
                        cnt   <= '0;
                    end
                end
                PH_HIGH: begin
                    if (cnt == HI_LAST) begin
                        phase <= PH_LOW;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PH_LOW: begin
                    if (cnt == LO_LAST) begin
                        phase <= PH_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    phase <= PH_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign step    = (phase == PH_HIGH);
    assign hi_done = (phase == PH_HIGH) && (cnt == HI_LAST);
    assign done    = (phase == PH_LOW) && (cnt == LO_LAST);
    assign busy    = (phase != PH_IDLE);

endmodule

// File: rtl/debug_scan_ctrl.sv
// Host-side debug-port reader: single-steps the core and sweeps the debug
// address space, streaming {addr, data} beats over valid/ready.
module debug_scan_ctrl
    import dbg_pkg::*;
#(
    parameter int unsigned            STEP_HIGH_CYC = 4,
    parameter int unsigned            STEP_LOW_CYC  = 4,
    parameter logic [DBG_ADDR_W-1:0]  FIRST_ADDR    = DBG_REG_BANK,
    parameter logic [DBG_ADDR_W-1:0]  LAST_ADDR     = DBG_TEST_BANK + 7'd31
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  halt,
    input  logic                  step_req,
    input  logic                  scan_req,
    input  logic                  abort,
    output logic                  debug_en,
    output logic                  debug_step,
    output logic [DBG_ADDR_W-1:0] debug_addr,
    input  logic [DBG_DATA_W-1:0] debug_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DBG_ADDR_W-1:0] out_addr,
    output logic [DBG_DATA_W-1:0] out_data,
    output logic                  busy,
    output logic                  done
);

    scan_state_e state, state_nxt;
    logic        pending;      // sweep requested together with a step
    logic        abort_q;      // abort seen earlier in the current beat
    logic        step_start;
    logic        step_hi_done;
    logic        step_done;
    logic        step_busy;

    wire step_go   = step_req && debug_en;
    wire beat_done = out_valid && out_ready;
    wire sweep_end = abort || abort_q || (debug_addr == LAST_ADDR);

    dbg_step_pulse #(
        .HIGH_CYC (STEP_HIGH_CYC),
        .LOW_CYC  (STEP_LOW_CYC)
    ) u_step_pulse (
        .clk     (clk),
        .rst     (rst),
        .start   (step_start),
        .step    (debug_step),
        .hi_done (step_hi_done),
        .done    (step_done),
        .busy    (step_busy)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode.
    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (step_go)       state_nxt = ST_STEP_HI;
                else if (scan_req) state_nxt = ST_SET_ADDR;
            end
            ST_STEP_HI:  if (step_hi_done) state_nxt = ST_STEP_LO;
            ST_STEP_LO: begin
                if (step_done) state_nxt = (pending && !abort) ? ST_SET_ADDR : ST_FINISH;
            end
            ST_SET_ADDR: state_nxt = ST_CAPTURE;
            ST_CAPTURE:  state_nxt = ST_SEND;
            ST_SEND: begin
                if (beat_done) state_nxt = sweep_end ? ST_FINISH : ST_SET_ADDR;
            end
            ST_FINISH:   state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Status outputs and step-pulse launch.
    always_comb begin
        step_start = (state == ST_IDLE) && step_go;
        busy       = (state != ST_IDLE) || step_busy;
        done       = (state == ST_FINISH);
    end

    // Debug enable follows halt with one cycle of latency in every state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) debug_en <= 1'b0;
        else      debug_en <= halt;
    end

    // Sweep address, beat capture and handshake bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            debug_addr <= '0;
            out_valid  <= 1'b0;
            out_addr   <= '0;
            out_data   <= '0;
            pending    <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    pending <= step_go && scan_req;
                    abort_q <= 1'b0;
                    if (scan_req) debug_addr <= FIRST_ADDR;
                end
                ST_STEP_HI, ST_STEP_LO: begin
                    if (abort) pending <= 1'b0;
                end
                ST_SET_ADDR: begin
                    abort_q <= abort_q || abort;
                end
                ST_CAPTURE: begin
                    out_data  <= debug_data;
                    out_addr  <= debug_addr;
                    out_valid <= 1'b1;
                    abort_q   <= abort_q || abort;
                end
                ST_SEND: begin
                    if (beat_done) begin
                        out_valid <= 1'b0;
                        if (!sweep_end) debug_addr <= next_addr(debug_addr, LAST_ADDR);
                    end
                end
                ST_FINISH: begin
                    debug_addr <= '0;
                    pending    <= 1'b0;
                    abort_q    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_scan_ctrl.sv
// Self-checking bench for debug_scan_ctrl: core debug port modelled as data = addr*3,
// a per-cycle monitor checks beats against an expected-address queue.
module tb_debug_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt, step_req, scan_req, abort, out_ready;
    logic        debug_en, debug_step, out_valid, busy, done;
    logic [6:0]  debug_addr, out_addr;
    logic [31:0] debug_data, out_data;

    int checks   = 0;
    int failures = 0;

    int cyc = 0;
    int start_cyc = 0;
    int ready_mode = 0;

    // monitor statistics, cleared at the start of each request
    int step_hi_cnt, step_first, step_last;
    int done_cnt, done_rel;
    int beat_cnt, first_beat_rel, valid_cnt;
    logic [31:0] last_data;
    logic [6:0]  exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // core debug port: combinational read of the addressed register
    assign debug_data = 32'(debug_addr) * 32'd3;

    debug_scan_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .halt       (halt),
        .step_req   (step_req),
        .scan_req   (scan_req),
        .abort      (abort),
        .debug_en   (debug_en),
        .debug_step (debug_step),
        .debug_addr (debug_addr),
        .debug_data (debug_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        step_hi_cnt = 0; step_first = 0; step_last = 0;
        done_cnt = 0; done_rel = 0;
        beat_cnt = 0; first_beat_rel = 0; valid_cnt = 0;
        last_data = '0;
    endtask

    task automatic push_sweep(input int first, input int last);
        for (int a = first; a <= last; a++) exp_q.push_back(7'(a));
    endtask

    // one-cycle request pulse; start_cyc marks the edge that samples it
    task automatic pulse_req(input logic s, input logic c);
        @(posedge clk); #1;
        clear_stats();
        step_req = s;
        scan_req = c;
        @(posedge clk); #1;
        start_cyc = cyc;
        step_req = 1'b0;
        scan_req = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // sink ready pattern, updated just after each rising edge
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            out_ready = (ready_mode == 0) ? 1'b1 : (cyc % 3 == 0);
        end
    end

    // compare process: checks the DUT against the model on every cycle
    initial begin : monitor
        logic       prev_halt, pv, pr;
        logic [6:0] pa, ea;
        logic [31:0] pd;
        int rel;
        prev_halt = 1'b0; pv = 1'b0; pr = 1'b0; pa = '0; pd = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_halt = 1'b0;
                pv = 1'b0;
                continue;
            end
            check("debug_en_follows_halt", debug_en, prev_halt);
            prev_halt = halt;
            rel = cyc - start_cyc + 1;
            if (debug_step) begin
                step_hi_cnt++;
                if (step_first == 0) step_first = rel;
                step_last = rel;
            end
            if (done) begin
                done_cnt++;
                done_rel = rel;
            end
            if (out_valid) begin
                valid_cnt++;
                check("beat_data_model", out_data, 32'(out_addr) * 32'd3);
                check("no_step_in_sweep", debug_step, 1'b0);
            end
            if (pv && !pr) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_addr", out_addr, pa);
                check("hold_data", out_data, pd);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_beat: got beat addr %0d expected none", out_addr);
                end else begin
                    ea = exp_q.pop_front();
                    check("beat_addr", out_addr, ea);
                end
                beat_cnt++;
                last_data = out_data;
                if (first_beat_rel == 0) first_beat_rel = rel;
            end
            pv = out_valid; pr = out_ready; pa = out_addr; pd = out_data;
        end
    end

    initial begin
        int n;
        rst = 1'b0; halt = 1'b0; step_req = 1'b0; scan_req = 1'b0; abort = 1'b0;
        clear_stats();
        #1;
        check("rst_debug_en", debug_en, 0);
        check("rst_debug_step", debug_step, 0);
        check("rst_debug_addr", debug_addr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        halt = 1'b1;
        repeat (3) @(posedge clk);

        // 1: single step
        pulse_req(1'b1, 1'b0);
        wait_done("t1", 40);
        check("t1_step_high_cycles", step_hi_cnt, 4);
        check("t1_step_first", step_first, 1);
        check("t1_step_low_cycles", done_rel - step_last - 1, 4);
        check("t1_done_cycle", done_rel, 9);
        check("t1_done_count", done_cnt, 1);
        check("t1_no_valid", valid_cnt, 0);
        check("t1_idle", busy, 0);

        // 2: full sweep, sink always ready
        push_sweep(0, 63);
        pulse_req(1'b0, 1'b1);
        wait_done("t2", 400);
        check("t2_beats", beat_cnt, 64);
        check("t2_last_data", last_data, 189);
        check("t2_first_beat_cycle", first_beat_rel, 3);
        check("t2_done_cycle", done_rel, 193);
        check("t2_done_count", done_cnt, 1);
        check("t2_no_lost_beats", exp_q.size(), 0);
        check("t2_addr_home", debug_addr, 0);

        // 3: sweep with a slow sink
        ready_mode = 1;
        push_sweep(0, 63);
        pulse_req(1'b0, 1'b1);
        wait_done("t3", 1200);
        check("t3_beats", beat_cnt, 64);
        check("t3_last_data", last_data, 189);
        check("t3_done_count", done_cnt, 1);
        check("t3_no_lost_beats", exp_q.size(), 0);
        ready_mode = 0;
        repeat (2) @(posedge clk);

        // 4: step and sweep requested together
        push_sweep(0, 63);
        pulse_req(1'b1, 1'b1);
        wait_done("t4", 400);
        check("t4_step_high_cycles", step_hi_cnt, 4);
        check("t4_step_first", step_first, 1);
        check("t4_first_beat_cycle", first_beat_rel, 11);
        check("t4_beats", beat_cnt, 64);
        check("t4_done_cycle", done_rel, 201);
        check("t4_done_count", done_cnt, 1);
        check("t4_no_lost_beats", exp_q.size(), 0);

        // 5: abort while addressing beat 10
        push_sweep(0, 10);
        pulse_req(1'b0, 1'b1);
        n = 0;
        while (debug_addr != 7'd10 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("t5_reached_addr10", debug_addr, 10);
        abort = 1'b1;
        wait_done("t5", 100);
        abort = 1'b0;
        check("t5_beats", beat_cnt, 11);
        check("t5_last_data", last_data, 30);
        check("t5_done_cycle", done_rel, 34);
        check("t5_done_count", done_cnt, 1);
        check("t5_no_lost_beats", exp_q.size(), 0);
        check("t5_addr_home", debug_addr, 0);

        // 6: asynchronous reset in the middle of a step pulse
        pulse_req(1'b1, 1'b0);
        @(posedge clk); #3;
        check("t6_step_high_before_rst", debug_step, 1);
        rst = 1'b0;
        #1;
        check("t6_rst_step_low", debug_step, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_debug_en", debug_en, 0);
        halt = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        pulse_req(1'b1, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        check("t6_ignored_no_step", step_hi_cnt, 0);
        check("t6_ignored_no_done", done_cnt, 0);
        check("t6_ignored_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
